// File: rtl/linescanner_sensor_emulator.sv
// Line-scan sensor emulator: conversion phase, pixel readout, inter-line gap.
// Define LINESCANNER_EMULATOR_LINE_COUNTER_EN to offset pixel data by line_index.
module linescanner_sensor_emulator #(
    parameter int PIXELS_COUNT = 1024,
    parameter int ADC_CYCLES   = 16,
    parameter int LINE_GAP     = 4
) (
    input  logic       main_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       n_reset,
    input  logic       load_pulse,
    input  logic       rst_cvc,
    input  logic       rst_cds,
    output logic [7:0] data,
    output logic       sample,
    output logic       end_adc,
    output logic       lval,
    output logic       pixel_clock
);

    localparam int CW = $clog2(PIXELS_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADC,
        END_ADC,
        READOUT,
        GAP
    } state_t;

    state_t          state;
    logic [7:0]      adc_cnt;
    logic [7:0]      gap_cnt;
    logic [CW-1:0]   px;
    logic [CW-1:0]   px_inc;
    logic            phase;
    logic            load_q;
    logic            start;
    logic            last_px;
    logic [7:0]      line_ofs;

`ifdef LINESCANNER_EMULATOR_LINE_COUNTER_EN
    logic [7:0] line_index;
    assign line_ofs = line_index;
`else
    assign line_ofs = 8'd0;
`endif

    assign start   = load_pulse && !load_q && (state == IDLE)
                     && enable && n_reset;
    assign px_inc  = px + CW'(1);
    assign last_px = phase && (px == CW'(PIXELS_COUNT - 1));

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            adc_cnt     <= 8'd0;
            gap_cnt     <= 8'd0;
            px          <= '0;
            phase       <= 1'b0;
            load_q      <= 1'b0;
            data        <= 8'd0;
            sample      <= 1'b0;
            end_adc     <= 1'b0;
            lval        <= 1'b0;
            pixel_clock <= 1'b0;
`ifdef LINESCANNER_EMULATOR_LINE_COUNTER_EN
            line_index  <= 8'd0;
`endif
        end else begin
            load_q <= load_pulse;
            // Sensor reset and line abort override everything, including a start
            if (!n_reset || rst_cvc) begin
                state       <= IDLE;
                adc_cnt     <= 8'd0;
                gap_cnt     <= 8'd0;
                px          <= '0;
                phase       <= 1'b0;
                data        <= 8'd0;
                sample      <= 1'b0;
                end_adc     <= 1'b0;
                lval        <= 1'b0;
                pixel_clock <= 1'b0;
`ifdef LINESCANNER_EMULATOR_LINE_COUNTER_EN
                if (!n_reset) begin
                    line_index <= 8'd0;
                end
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= ADC;
                            adc_cnt <= 8'd0;
                            sample  <= 1'b1;
                        end
                    end
                    ADC: begin
                        if (rst_cds) begin
                            adc_cnt <= 8'd0;
                        end else if (adc_cnt == 8'(ADC_CYCLES - 1)) begin
                            state   <= END_ADC;
                            adc_cnt <= 8'd0;
                            sample  <= 1'b0;
                            end_adc <= 1'b1;
                        end else begin
                            adc_cnt <= adc_cnt + 8'd1;
                        end
                    end
                    END_ADC: begin
                        state       <= READOUT;
                        end_adc     <= 1'b0;
                        lval        <= 1'b1;
                        pixel_clock <= 1'b0;
                        px          <= '0;
                        phase       <= 1'b0;
                        data        <= line_ofs;
                    end
                    READOUT: begin
                        if (last_px) begin
                            state       <= GAP;
                            lval        <= 1'b0;
                            pixel_clock <= 1'b0;
                            data        <= 8'd0;
                            px          <= '0;
                            phase       <= 1'b0;
                            gap_cnt     <= 8'd0;
`ifdef LINESCANNER_EMULATOR_LINE_COUNTER_EN
                            line_index  <= line_index + 8'd1;
`endif
                        end else if (phase) begin
                            // New pixel value only enters at the start of a low phase
                            phase       <= 1'b0;
                            pixel_clock <= 1'b0;
                            px          <= px_inc;
                            data        <= 8'(px_inc) + line_ofs;
                        end else begin
                            phase       <= 1'b1;
                            pixel_clock <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 8'(LINE_GAP - 1)) begin
                            state   <= IDLE;
                            gap_cnt <= 8'd0;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/linescanner_sensor_emulator.md
LINESCANNER_SENSOR_EMULATOR -- requirements
Module: linescanner_sensor_emulator

Interface
REQ-001 The block SHALL have parameter PIXELS_COUNT, default 1024, pixels per line (range 1..4096).
REQ-002 The block SHALL have parameter ADC_CYCLES, default 16, clock cycles of the conversion phase (range 1..255).
REQ-003 The block SHALL have parameter LINE_GAP, default 4, idle cycles after each line (range 1..255).
REQ-004 Port main_clock  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  1  permits new line starts.
REQ-007 Port n_reset  input  1  synchronous active-low sensor reset from the capture side.
REQ-008 Port load_pulse  input  1  line start request; rising edge significant.
REQ-009 Port rst_cvc  input  1  synchronous line abort.
REQ-010 Port rst_cds  input  1  conversion restart.
REQ-011 Port data  output  8  pixel value.
REQ-012 Port sample  output  1  high during conversion phase.
REQ-013 Port end_adc  output  1  one-cycle end-of-conversion strobe.
REQ-014 Port lval  output  1  line valid.
REQ-015 Port pixel_clock  output  1  pixel clock, main_clock/2 during readout.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The state machine SHALL have states IDLE, ADC, END_ADC, READOUT, GAP.
REQ-018 A start SHALL be detected in cycle N when load_pulse=1, registered previous load_pulse=0, state=IDLE, enable=1, n_reset=1; otherwise load_pulse is ignored, including while busy.
REQ-019 After a start in cycle N, ADC SHALL occupy cycles N+1..N+ADC_CYCLES with sample=1.
REQ-020 END_ADC SHALL occupy cycle N+ADC_CYCLES+1 with end_adc=1, sample=0.
REQ-021 READOUT SHALL start at cycle N+ADC_CYCLES+2 and last 2*PIXELS_COUNT cycles with lval=1.
REQ-022 In READOUT, pixel_clock SHALL be 0 on the even (first) cycle and 1 on the odd cycle of each pixel; data SHALL change only at the start of a low phase and stay stable through the following rising pixel_clock.
REQ-023 Pixel k (0-based) SHALL carry data = (k + line_index) mod 256 when the configuration feature is present.
REQ-024 After the last pixel, GAP SHALL last LINE_GAP cycles with lval=0, pixel_clock=0, data=0, then return to IDLE.
REQ-025 line_index (8 bits, internal) SHALL increment by 1 at READOUT completion and wrap 255->0.
REQ-026 rst_cvc=1 in any state SHALL move to IDLE next cycle, drive all outputs 0, leave line_index unchanged.
REQ-027 rst_cds=1 while in ADC SHALL restart the ADC count (ADC_CYCLES further cycles from the next cycle); rst_cds is ignored in other states.
REQ-028 rst_cvc SHALL take priority over rst_cds and over a simultaneous start.
REQ-029 enable falling mid-line SHALL NOT affect the current line; only new starts are blocked.
REQ-030 n_reset=0 SHALL behave as rst_cvc and additionally clear line_index to 0.
REQ-031 In IDLE all outputs SHALL be 0.

Reset
REQ-032 reset=1 SHALL asynchronously force state IDLE, line_index=0, pixel counter=0, ADC counter=0, registered load_pulse=0, and data=0, sample=0, end_adc=0, lval=0, pixel_clock=0.
REQ-033 reset mid-line SHALL abort the line; the first start after release SHALL produce line_index 0.

Configuration
REQ-034 Macro LINESCANNER_EMULATOR_LINE_COUNTER_EN defined: data SHALL follow REQ-023 and line_index logic SHALL exist.
REQ-035 Macro undefined: line_index SHALL not be built and data SHALL be k mod 256 for every line; all timing is unchanged.

Verification (PIXELS_COUNT=8, ADC_CYCLES=4, LINE_GAP=2, macro defined unless stated)
REQ-036 load_pulse rises at cycle 10 with enable=1 -> sample=1 cycles 11-14, end_adc=1 cycle 15, lval=1 cycles 16-31, data 0..7, GAP cycles 32-33, IDLE at 34.
REQ-037 Three back-to-back lines -> line 2 data 2..9; after 256 lines, line_index wraps and data restarts at 0..7.
REQ-038 rst_cvc=1 at the 5th READOUT cycle -> all outputs 0 next cycle, IDLE; next line data starts at the same line_index.
REQ-039 rst_cds=1 in the 2nd ADC cycle -> sample stays high 4 more cycles, then end_adc; load_pulse pulses during READOUT are ignored.
REQ-040 reset asserted mid-READOUT -> outputs 0 immediately, without waiting for a clock edge; macro undefined -> every line carries data 0..7.
